// File: rtl/multi_channel_fifo_controller_if.sv
// -----------------------------------------------------------------------------
// multi_channel_fifo_controller_if
// Bundles every signal of the multi-channel FIFO controller except clock and
// reset.
//   slave  : the controller's view. It takes the write/read requests, flush,
//            thresholds and memory read data, and drives the status, count,
//            error and memory-port signals.
//   master : the system's view, which issues requests and hosts the memory.
// Signal groups:
//   flush                                    per-channel flush mask
//   write_enable/channel/data, write_miss    write side
//   read_enable/channel, read_data, read_error
//                                            read side
//   empty .. almost_full, level, space       per-channel status
//   lower/upper_threshold_level/status       shared thresholds, per-channel flags
//   memory_*                                 port to the shared storage memory
// -----------------------------------------------------------------------------
interface multi_channel_fifo_controller_if #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 2
);
   localparam int DEPTH_LOG2    = $clog2(DEPTH);
   localparam int CHANNEL_LOG2  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH);
   localparam int COUNT_WIDTH   = DEPTH_LOG2 + 1;

   logic [CHANNELS-1:0]             flush;
   logic                            write_enable;
   logic [CHANNEL_LOG2-1:0]         write_channel;
   logic [WIDTH-1:0]                write_data;
   logic [CHANNELS-1:0]             write_miss;
   logic                            read_enable;
   logic [CHANNEL_LOG2-1:0]         read_channel;
   logic [WIDTH-1:0]                read_data;
   logic [CHANNELS-1:0]             read_error;
   logic [CHANNELS-1:0]             empty;
   logic [CHANNELS-1:0]             not_empty;
   logic [CHANNELS-1:0]             almost_empty;
   logic [CHANNELS-1:0]             full;
   logic [CHANNELS-1:0]             not_full;
   logic [CHANNELS-1:0]             almost_full;
   logic [CHANNELS*COUNT_WIDTH-1:0] level;
   logic [CHANNELS*COUNT_WIDTH-1:0] space;
   logic [COUNT_WIDTH-1:0]          lower_threshold_level;
   logic [COUNT_WIDTH-1:0]          upper_threshold_level;
   logic [CHANNELS-1:0]             lower_threshold_status;
   logic [CHANNELS-1:0]             upper_threshold_status;
   logic                            memory_clock;
   logic                            memory_write_enable;
   logic [ADDRESS_WIDTH-1:0]        memory_write_address;
   logic [WIDTH-1:0]                memory_write_data;
   logic                            memory_read_enable;
   logic [ADDRESS_WIDTH-1:0]        memory_read_address;
   logic [WIDTH-1:0]                memory_read_data;

   modport slave (
      input  flush, write_enable, write_channel, write_data,
             read_enable, read_channel,
             lower_threshold_level, upper_threshold_level, memory_read_data,
      output write_miss, read_data, read_error,
             empty, not_empty, almost_empty, full, not_full, almost_full,
             level, space, lower_threshold_status, upper_threshold_status,
             memory_clock, memory_write_enable, memory_write_address,
             memory_write_data, memory_read_enable, memory_read_address
   );

   modport master (
      output flush, write_enable, write_channel, write_data,
             read_enable, read_channel,
             lower_threshold_level, upper_threshold_level, memory_read_data,
      input  write_miss, read_data, read_error,
             empty, not_empty, almost_empty, full, not_full, almost_full,
             level, space, lower_threshold_status, upper_threshold_status,
             memory_clock, memory_write_enable, memory_write_address,
             memory_write_data, memory_read_enable, memory_read_address
   );
endinterface

// File: rtl/multi_channel_fifo_controller.sv
// -----------------------------------------------------------------------------
// multi_channel_fifo_controller
// Manages CHANNELS independent FIFO queues of DEPTH entries each, all stored in
// one external memory. Channel c owns addresses c*DEPTH .. c*DEPTH+DEPTH-1.
// The controller only holds pointers. Data passes straight through to and from
// the memory port, and read data is the combinational head of read_channel.
// Ports:
//   clock  sole clock; also forwarded to memory_clock
//   reset  asynchronous, active-high; empties every channel immediately
//   bus    multi_channel_fifo_controller_if.slave (requests, status, memory)
// -----------------------------------------------------------------------------
module multi_channel_fifo_controller #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 2
) (
   input logic clock,
   input logic reset,
   multi_channel_fifo_controller_if.slave bus
);
   localparam int DEPTH_LOG2    = $clog2(DEPTH);
   localparam int CHANNEL_LOG2  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH);
   localparam int POINTER_WIDTH = DEPTH_LOG2 + 1;

   localparam logic [POINTER_WIDTH-1:0] DEPTH_COUNT  = POINTER_WIDTH'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0]    LAST_ADDRESS = DEPTH_LOG2'(DEPTH - 1);

   // Pointer layout: the low bits hold the local address and the MSB is the
   // lap bit. The address wraps at DEPTH-1, which need not be a power of two,
   // so a plain increment cannot be used.
   function automatic logic [POINTER_WIDTH-1:0] next_pointer(
      input logic [POINTER_WIDTH-1:0] pointer
   );
      if (pointer[DEPTH_LOG2-1:0] == LAST_ADDRESS) begin
         return {~pointer[DEPTH_LOG2], {DEPTH_LOG2{1'b0}}};
      end
      return pointer + POINTER_WIDTH'(1);
   endfunction

   logic [CHANNELS-1:0][POINTER_WIDTH-1:0] write_pointer;
   logic [CHANNELS-1:0][POINTER_WIDTH-1:0] read_pointer;
   logic [CHANNELS-1:0][POINTER_WIDTH-1:0] channel_level;
   logic [CHANNELS-1:0][ADDRESS_WIDTH-1:0] write_address;
   logic [CHANNELS-1:0][ADDRESS_WIDTH-1:0] read_address;

   logic [CHANNELS-1:0] is_empty;
   logic [CHANNELS-1:0] is_full;
   logic [CHANNELS-1:0] is_almost_empty;
   logic [CHANNELS-1:0] is_almost_full;
   logic [CHANNELS-1:0] lower_status;
   logic [CHANNELS-1:0] upper_status;
   logic [CHANNELS-1:0] write_select;
   logic [CHANNELS-1:0] read_select;
   logic [CHANNELS-1:0] write_accept;
   logic [CHANNELS-1:0] read_accept;
   logic [CHANNELS-1:0] write_reject;
   logic [CHANNELS-1:0] read_reject;
   logic [CHANNELS-1:0] write_miss;
   logic [CHANNELS-1:0] read_error;

   logic [CHANNELS*POINTER_WIDTH-1:0] level_flat;
   logic [CHANNELS*POINTER_WIDTH-1:0] space_flat;

   logic                     same_channel;
   logic [ADDRESS_WIDTH-1:0] memory_write_address;
   logic [ADDRESS_WIDTH-1:0] memory_read_address;
   logic                     memory_read_enable;
   logic [WIDTH-1:0]         head_data;

   // A write to a full channel is still accepted when the same cycle pops
   // that channel. The read frees the slot that the write fills.
   assign same_channel = (bus.write_channel == bus.read_channel);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
      localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(c * DEPTH);

      logic                  lap_differ;
      logic                  address_equal;
      logic [DEPTH_LOG2-1:0] write_local;
      logic [DEPTH_LOG2-1:0] read_local;

      assign write_local   = write_pointer[c][DEPTH_LOG2-1:0];
      assign read_local    = read_pointer[c][DEPTH_LOG2-1:0];
      assign lap_differ    = write_pointer[c][DEPTH_LOG2] != read_pointer[c][DEPTH_LOG2];
      assign address_equal = (write_local == read_local);

      assign is_empty[c] = address_equal && !lap_differ;
      assign is_full[c]  = address_equal && lap_differ;

      // When the laps differ the writer is one lap ahead, so its local
      // address is numerically behind. Adding DEPTH restores the true
      // distance. The sum is taken modulo 2^POINTER_WIDTH and always lands
      // in the range 0..DEPTH.
      assign channel_level[c] = {1'b0, write_local} - {1'b0, read_local}
                              + (lap_differ ? DEPTH_COUNT : '0);

      assign level_flat[c*POINTER_WIDTH +: POINTER_WIDTH] = channel_level[c];
      assign space_flat[c*POINTER_WIDTH +: POINTER_WIDTH] = DEPTH_COUNT - channel_level[c];

      assign is_almost_empty[c] = (channel_level[c] == POINTER_WIDTH'(1));
      assign is_almost_full[c]  = (DEPTH_COUNT - channel_level[c] == POINTER_WIDTH'(1));
      assign lower_status[c]    = (channel_level[c] <= bus.lower_threshold_level);
      assign upper_status[c]    = (channel_level[c] >= bus.upper_threshold_level);

      assign write_address[c] = BASE + ADDRESS_WIDTH'(write_local);
      assign read_address[c]  = BASE + ADDRESS_WIDTH'(read_local);

      // A channel number that selects no existing channel matches no select
      // line, so the request is dropped without raising a flag.
      assign write_select[c] = (bus.write_channel == CHANNEL_LOG2'(c));
      assign read_select[c]  = (bus.read_channel == CHANNEL_LOG2'(c));

      assign write_accept[c] = bus.write_enable && write_select[c] && !bus.flush[c]
                             && (!is_full[c] || (bus.read_enable && same_channel));
      assign write_reject[c] = bus.write_enable && write_select[c] && !bus.flush[c]
                             && !write_accept[c];
      assign read_accept[c]  = bus.read_enable && read_select[c] && !bus.flush[c]
                             && !is_empty[c];
      assign read_reject[c]  = bus.read_enable && read_select[c] && !bus.flush[c]
                             && is_empty[c];
   end

   always_comb begin
      memory_write_address = '0;
      memory_read_address  = '0;
      memory_read_enable   = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (write_select[c]) begin
            memory_write_address = write_address[c];
         end
         if (read_select[c]) begin
            memory_read_address = read_address[c];
            memory_read_enable  = !is_empty[c];
         end
      end
   end

   // Pointer state. A flush collapses the channel by moving the read pointer
   // onto the write pointer. Writes to a flushing channel are already
   // blocked, so the write pointer cannot move in that same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_pointer <= '0;
         read_pointer  <= '0;
         write_miss    <= '0;
         read_error    <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (write_accept[c]) begin
               write_pointer[c] <= next_pointer(write_pointer[c]);
            end
            if (bus.flush[c]) begin
               read_pointer[c] <= write_pointer[c];
            end else if (read_accept[c]) begin
               read_pointer[c] <= next_pointer(read_pointer[c]);
            end
         end
         write_miss <= write_reject;
         read_error <= read_reject;
      end
   end

   assign head_data = bus.memory_read_data;

   assign bus.read_data              = head_data;
   assign bus.write_miss             = write_miss;
   assign bus.read_error             = read_error;
   assign bus.empty                  = is_empty;
   assign bus.not_empty              = ~is_empty;
   assign bus.almost_empty           = is_almost_empty;
   assign bus.full                   = is_full;
   assign bus.not_full               = ~is_full;
   assign bus.almost_full            = is_almost_full;
   assign bus.level                  = level_flat;
   assign bus.space                  = space_flat;
   assign bus.lower_threshold_status = lower_status;
   assign bus.upper_threshold_status = upper_status;
   assign bus.memory_clock           = clock;
   assign bus.memory_write_enable    = |write_accept;
   assign bus.memory_write_address   = memory_write_address;
   assign bus.memory_write_data      = bus.write_data;
   assign bus.memory_read_enable     = memory_read_enable;
   assign bus.memory_read_address    = memory_read_address;
endmodule
